// File: rtl/next_pc_unit.sv
// next_pc_unit
// ------------------------------------------------------------------------
// Owns the fetch PC register and resolves control flow coming back from
// the execute stage. Conditional branches are evaluated here from funct3
// and the two operands; JAL/JALR redirects, fetch stalls, misaligned
// target traps and simple branch statistics are handled as well.
//
// Ports
//   iClk, iRstN          clock (rising edge), async active-low reset
//   iStall               hold the fetch PC when nothing redirects
//   iValid               execute-stage instruction is valid
//   iBranch, iJump       conditional branch / JAL-JALR (jump has priority)
//   iPcSrc               with iJump: 1 = JALR, 0 = JAL
//   iFunct3              branch condition code
//   iPcEx                PC of the execute-stage instruction
//   iRs1, iRs2, iOffset  operands and sign-extended immediate
//   iExcAck              acknowledge of a pending misalign trap
//   oPc                  registered fetch PC
//   oFlush               one-cycle pulse per redirect, trap entry, trap exit
//   oMisalign            sticky trap flag, cleared by iExcAck
//   oMisalignPc          iPcEx of the faulting instruction
//   oBranchCnt           resolved conditional branches (saturating)
//   oTakenCnt            taken branches plus jumps (saturating)
// ------------------------------------------------------------------------
module next_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter int              CNT_W    = 32
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iStall,
    input  logic             iValid,
    input  logic             iBranch,
    input  logic             iJump,
    input  logic             iPcSrc,
    input  logic [2:0]       iFunct3,
    input  logic [XLEN-1:0]  iPcEx,
    input  logic [XLEN-1:0]  iRs1,
    input  logic [XLEN-1:0]  iRs2,
    input  logic [XLEN-1:0]  iOffset,
    input  logic             iExcAck,
    output logic [XLEN-1:0]  oPc,
    output logic             oFlush,
    output logic             oMisalign,
    output logic [XLEN-1:0]  oMisalignPc,
    output logic [CNT_W-1:0] oBranchCnt,
    output logic [CNT_W-1:0] oTakenCnt
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t          state, state_nxt;
    logic            cond;
    logic            taken;
    logic            misaligned;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_nxt;
    logic            flush_nxt;
    logic            mis_nxt;
    logic [XLEN-1:0] mis_pc_nxt;
    logic            branch_inc;
    logic            taken_inc;

    // Branch condition; the undefined codes 010/011 simply never take.
    always_comb begin
        cond = 1'b0;
        case (iFunct3)
            3'b000:  cond = (iRs1 == iRs2);
            3'b001:  cond = (iRs1 != iRs2);
            3'b100:  cond = ($signed(iRs1) <  $signed(iRs2));
            3'b101:  cond = ($signed(iRs1) >= $signed(iRs2));
            3'b110:  cond = (iRs1 <  iRs2);
            3'b111:  cond = (iRs1 >= iRs2);
            default: cond = 1'b0;
        endcase
    end

    // JALR clears bit 0 of its sum; only bit 1 can then make a target misaligned.
    assign jalr_sum   = iRs1 + iOffset;
    assign target     = (iJump && iPcSrc) ? {jalr_sum[XLEN-1:1], 1'b0} : (iPcEx + iOffset);
    assign taken      = iValid & (iJump | (iBranch & cond));
    assign misaligned = taken & target[1];

    // Next-state and next-register values; TRAP ignores execute traffic entirely.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = oPc;
        flush_nxt  = 1'b0;
        mis_nxt    = oMisalign;
        mis_pc_nxt = oMisalignPc;
        branch_inc = 1'b0;
        taken_inc  = 1'b0;
        case (state)
            RUN: begin
                branch_inc = iValid & iBranch & ~iJump;
                taken_inc  = taken;
                if (taken && misaligned) begin
                    state_nxt  = TRAP;
                    mis_nxt    = 1'b1;
                    mis_pc_nxt = iPcEx;
                    flush_nxt  = 1'b1;
                end else if (taken) begin
                    pc_nxt    = target;
                    flush_nxt = 1'b1;
                end else if (!iStall) begin
                    pc_nxt = oPc + XLEN'(4);
                end
            end
            TRAP: begin
                if (iExcAck) begin
                    state_nxt = RUN;
                    pc_nxt    = TRAP_VEC;
                    mis_nxt   = 1'b0;
                    flush_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state       <= RUN;
            oPc         <= RESET_PC;
            oFlush      <= 1'b0;
            oMisalign   <= 1'b0;
            oMisalignPc <= '0;
        end else begin
            state       <= state_nxt;
            oPc         <= pc_nxt;
            oFlush      <= flush_nxt;
            oMisalign   <= mis_nxt;
            oMisalignPc <= mis_pc_nxt;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oBranchCnt <= '0;
            oTakenCnt  <= '0;
        end else begin
            if (branch_inc && (oBranchCnt != {CNT_W{1'b1}}))
                oBranchCnt <= oBranchCnt + CNT_W'(1);
            if (taken_inc && (oTakenCnt != {CNT_W{1'b1}}))
                oTakenCnt <= oTakenCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit
// ------------------------------------------------------------------------
// Directed bench for next_pc_unit (CNT_W = 4 so saturation is reachable).
// The stimulus process pushes hand-computed expected register states into
// a queue; a separate monitor pops and compares them on each falling edge,
// or immediately when an asynchronous-reset check is requested.
// ------------------------------------------------------------------------
module tb_next_pc_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             valid = 1'b0;
    logic             branch = 1'b0;
    logic             jump = 1'b0;
    logic             pc_src = 1'b0;
    logic [2:0]       funct3 = 3'b000;
    logic [XLEN-1:0]  pc_ex = '0;
    logic [XLEN-1:0]  rs1 = '0;
    logic [XLEN-1:0]  rs2 = '0;
    logic [XLEN-1:0]  offset = '0;
    logic             exc_ack = 1'b0;
    logic [XLEN-1:0]  pc;
    logic             flush;
    logic             misalign;
    logic [XLEN-1:0]  misalign_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    always #5 clk = ~clk;

    next_pc_unit #(
        .XLEN(XLEN),
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W(CNT_W)
    ) dut (
        .iClk(clk),
        .iRstN(rst_n),
        .iStall(stall),
        .iValid(valid),
        .iBranch(branch),
        .iJump(jump),
        .iPcSrc(pc_src),
        .iFunct3(funct3),
        .iPcEx(pc_ex),
        .iRs1(rs1),
        .iRs2(rs2),
        .iOffset(offset),
        .iExcAck(exc_ack),
        .oPc(pc),
        .oFlush(flush),
        .oMisalign(misalign),
        .oMisalignPc(misalign_pc),
        .oBranchCnt(branch_cnt),
        .oTakenCnt(taken_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] mis_pc;
        logic [3:0]  bcnt;
        logic [3:0]  tcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    event sample_ev;

    task automatic pushExpect(input string name, input logic [31:0] e_pc, input logic e_flush,
                              input logic e_mis, input logic [31:0] e_mis_pc,
                              input logic [3:0] e_bcnt, input logic [3:0] e_tcnt);
        exp_t e;
        e.name   = name;
        e.pc     = e_pc;
        e.flush  = e_flush;
        e.mis    = e_mis;
        e.mis_pc = e_mis_pc;
        e.bcnt   = e_bcnt;
        e.tcnt   = e_tcnt;
        exp_q.push_back(e);
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = exp_q.pop_front();
        checkField(e.name, "pc", pc, e.pc);
        checkField(e.name, "flush", {31'b0, flush}, {31'b0, e.flush});
        checkField(e.name, "misalign", {31'b0, misalign}, {31'b0, e.mis});
        checkField(e.name, "misalign_pc", misalign_pc, e.mis_pc);
        checkField(e.name, "branch_cnt", {28'b0, branch_cnt}, {28'b0, e.bcnt});
        checkField(e.name, "taken_cnt", {28'b0, taken_cnt}, {28'b0, e.tcnt});
    endtask

    // Monitor: compares one expected state per falling edge or explicit request.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) checkOutput();
        end
    end

    // Drives one execute-stage vector, then returns just after the rising edge.
    task automatic applyStimulus(input logic v, input logic br, input logic jp, input logic src,
                                 input logic [2:0] f3, input logic [31:0] pe,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] off, input logic st, input logic ack);
        @(negedge clk);
        valid   = v;
        branch  = br;
        jump    = jp;
        pc_src  = src;
        funct3  = f3;
        pc_ex   = pe;
        rs1     = a;
        rs2     = b;
        offset  = off;
        stall   = st;
        exc_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic st);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, st, 1'b0);
    endtask

    logic [31:0] pc_e;
    int          b_e;
    int          t_e;

    initial begin
        // Reset state, checked while reset is still asserted.
        #1;
        pushExpect("reset", 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
        -> sample_ev;
        @(posedge clk);
        #2 rst_n = 1'b1;

        idleCycle(1'b0); pushExpect("seq4",  32'h4, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
        idleCycle(1'b0); pushExpect("seq8",  32'h8, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
        idleCycle(1'b0); pushExpect("seq12", 32'hC, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);

        applyStimulus(1, 1, 0, 0, 3'b000, 32'h40, 32'd5, 32'd5, 32'h20, 0, 0);
        pushExpect("beq_taken", 32'h60, 1'b1, 1'b0, 32'h0, 4'd1, 4'd1);
        applyStimulus(1, 1, 0, 0, 3'b000, 32'h40, 32'd5, 32'd6, 32'h20, 0, 0);
        pushExpect("beq_not", 32'h64, 1'b0, 1'b0, 32'h0, 4'd2, 4'd1);
        applyStimulus(1, 1, 0, 0, 3'b100, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0);
        pushExpect("blt_taken", 32'h90, 1'b1, 1'b0, 32'h0, 4'd3, 4'd2);
        applyStimulus(1, 1, 0, 0, 3'b110, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0);
        pushExpect("bltu_not", 32'h94, 1'b0, 1'b0, 32'h0, 4'd4, 4'd2);
        applyStimulus(1, 1, 0, 0, 3'b001, 32'h94, 32'd1, 32'd2, 32'hFFFF_FFF0, 0, 0);
        pushExpect("bne_back", 32'h84, 1'b1, 1'b0, 32'h0, 4'd5, 4'd3);
        applyStimulus(1, 1, 0, 0, 3'b101, 32'h84, 32'd2, 32'd2, 32'h8, 0, 0);
        pushExpect("bge_taken", 32'h8C, 1'b1, 1'b0, 32'h0, 4'd6, 4'd4);
        applyStimulus(1, 1, 0, 0, 3'b111, 32'h8C, 32'd1, 32'hFFFF_FFFF, 32'h8, 0, 0);
        pushExpect("bgeu_not", 32'h90, 1'b0, 1'b0, 32'h0, 4'd7, 4'd4);
        applyStimulus(1, 1, 0, 0, 3'b010, 32'h90, 32'd3, 32'd3, 32'h8, 0, 0);
        pushExpect("f3_010", 32'h94, 1'b0, 1'b0, 32'h0, 4'd8, 4'd4);
        idleCycle(1'b1); pushExpect("stall", 32'h94, 1'b0, 1'b0, 32'h0, 4'd8, 4'd4);

        // JAL with iBranch also set: jump wins and the branch is not counted.
        applyStimulus(1, 1, 1, 0, 3'b001, 32'h94, 32'd7, 32'd7, 32'h100, 0, 0);
        pushExpect("jal", 32'h194, 1'b1, 1'b0, 32'h0, 4'd8, 4'd5);
        applyStimulus(0, 1, 0, 0, 3'b000, 32'h194, 32'd1, 32'd1, 32'h40, 0, 0);
        pushExpect("no_valid", 32'h198, 1'b0, 1'b0, 32'h0, 4'd8, 4'd5);

        // Misaligned JALR under stall enters the trap.
        applyStimulus(1, 0, 1, 1, 3'b000, 32'h198, 32'h103, 32'h0, 32'h0, 1, 0);
        pushExpect("trap_in", 32'h198, 1'b1, 1'b1, 32'h198, 4'd8, 4'd6);
        applyStimulus(1, 1, 0, 0, 3'b000, 32'h300, 32'd4, 32'd4, 32'h0, 0, 0);
        pushExpect("trap_hold", 32'h198, 1'b0, 1'b1, 32'h198, 4'd8, 4'd6);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
        pushExpect("trap_ack", 32'h100, 1'b1, 1'b0, 32'h198, 4'd8, 4'd6);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
        pushExpect("ack_in_run", 32'h104, 1'b0, 1'b0, 32'h198, 4'd8, 4'd6);

        applyStimulus(1, 0, 1, 1, 3'b000, 32'h104, 32'h201, 32'h0, 32'h3, 1, 0);
        pushExpect("jalr_stall", 32'h204, 1'b1, 1'b0, 32'h198, 4'd8, 4'd7);
        idleCycle(1'b1); pushExpect("flush_once", 32'h204, 1'b0, 1'b0, 32'h198, 4'd8, 4'd7);

        // PC increment wraps from 2^32-4 to 0.
        applyStimulus(1, 0, 1, 0, 3'b000, 32'h204, 32'h0, 32'h0, 32'hFFFF_FDF8, 0, 0);
        pushExpect("jal_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h198, 4'd8, 4'd8);
        idleCycle(1'b0); pushExpect("pc_wrap", 32'h0, 1'b0, 1'b0, 32'h198, 4'd8, 4'd8);

        // 17 taken BNEs drive both 4-bit counters into saturation.
        pc_e = 32'h0;
        b_e  = 8;
        t_e  = 8;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 1, 0, 0, 3'b001, pc_e, 32'd1, 32'd0, 32'h8, 0, 0);
            pc_e = pc_e + 32'h8;
            b_e  = (b_e == 15) ? 15 : b_e + 1;
            t_e  = (t_e == 15) ? 15 : t_e + 1;
            pushExpect($sformatf("bne_sat%0d", i), pc_e, 1'b1, 1'b0, 32'h198, 4'(b_e), 4'(t_e));
        end

        // Asynchronous reset between clock edges clears everything at once.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        pushExpect("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
        -> sample_ev;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idleCycle(1'b0); pushExpect("after_rst", 32'h4, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);

        // A redirect presented while reset hits is discarded.
        @(negedge clk);
        valid  = 1'b1;
        branch = 1'b1;
        funct3 = 3'b000;
        pc_ex  = 32'h40;
        rs1    = 32'd9;
        rs2    = 32'd9;
        offset = 32'h20;
        #2 rst_n = 1'b0;
        #1;
        pushExpect("rst_discard", 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
        -> sample_ev;
        valid  = 1'b0;
        branch = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idleCycle(1'b0); pushExpect("discard_run", 32'h4, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
